// File: rtl/seq_ctrl.sv
// seq_ctrl: instruction-decode controller for a program-counter sequencer.
// Decodes the word at PC each cycle and requests increment, branch or hold.
// Holds a RUN/HALTED/ERR state machine, a loop counter and a return stack.
// The next-PC request (BADR/hlt/bra) is combinational; the sequencer and
// this block's state both update on the same rising edge.
module seq_ctrl #(
  parameter int STACK_DEPTH = 4,
  parameter int LC_W        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   PC,
  input  logic [15:0]                  instr,
  input  logic                         cond,
  input  logic                         start,
  output logic [9:0]                   BADR,
  output logic                         hlt,
  output logic                         bra,
  output logic                         halted,
  output logic                         err,
  output logic [$clog2(STACK_DEPTH):0] sp
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LC_W-1:0]   lc_q, lc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [9:0]        stack_q [STACK_DEPTH];
  logic [9:0]        stack_d [STACK_DEPTH];
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  logic [3:0]        opcode;
  logic [9:0]        target;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  push_idx;
  logic              stack_full;
  logic              stack_empty;

  assign opcode      = instr[15:12];
  assign target      = instr[9:0];
  assign top_idx     = PTR_W'(sp_q - 1'b1);
  assign push_idx    = sp_q[PTR_W-1:0];
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  // Decode: next-PC request plus next state, loop counter and stack contents.
  always_comb begin
    state_d = state_q;
    lc_d    = lc_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    bra     = 1'b0;
    hlt     = 1'b0;
    BADR    = 10'd0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          case (opcode)
            4'h0: ; // NOP: increment
            4'h1: begin
              bra  = 1'b1;
              BADR = target;
            end
            4'h2: begin
              bra     = 1'b1;
              hlt     = 1'b1;
              state_d = ST_HALTED;
            end
            4'h3: lc_d = instr[LC_W-1:0];
            4'h4: begin
              if (lc_q != '0) begin
                lc_d = lc_q - 1'b1;
                bra  = 1'b1;
                BADR = target;
              end
            end
            4'h5: begin
              if (!stack_full) begin
                stack_d[push_idx] = PC + 10'd1;
                sp_d              = sp_q + 1'b1;
                bra               = 1'b1;
                BADR              = target;
              end else begin
                bra     = 1'b1;
                hlt     = 1'b1;
                state_d = ST_ERR;
              end
            end
            4'h6: begin
              if (!stack_empty) begin
                sp_d = sp_q - 1'b1;
                bra  = 1'b1;
                BADR = stack_q[top_idx];
              end else begin
                bra     = 1'b1;
                hlt     = 1'b1;
                state_d = ST_ERR;
              end
            end
            4'h7: begin
              if (cond) begin
                bra  = 1'b1;
                BADR = target;
              end
            end
            default: begin
              bra     = 1'b1;
              hlt     = 1'b1;
              state_d = ST_ERR;
            end
          endcase
        end
        ST_HALTED: begin
          // start steps past the HALT word; otherwise keep holding on it
          if (start) begin
            state_d = ST_RUN;
          end else begin
            bra = 1'b1;
            hlt = 1'b1;
          end
        end
        default: begin
          bra = 1'b1;
          hlt = 1'b1;
        end
      endcase
    end
    halted_d = (state_d == ST_HALTED);
    err_d    = (state_d == ST_ERR);
  end

  // State register; reset discards any push/pop decoded in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      lc_q     <= '0;
      sp_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      lc_q     <= lc_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign halted = halted_q;
  assign err    = err_q;
  assign sp     = sp_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed vectors for seq_ctrl. Each vector drives one
// instruction cycle and queues the hand-computed response
// {bra, hlt, BADR, halted, err, sp} seen during that cycle; a monitor pops
// and compares on the falling edge.
module tb_seq_ctrl;

  localparam int EW = 17;

  logic        clk;
  logic        rst;
  logic [9:0]  pc;
  logic [15:0] instr;
  logic        cond;
  logic        start;
  logic [9:0]  badr;
  logic        hlt;
  logic        bra;
  logic        halted;
  logic        err;
  logic [2:0]  sp;

  logic [EW-1:0] exp_q[$];
  int            id_q[$];
  int            n_checks;
  int            n_errors;
  int            vec_id;

  seq_ctrl #(.STACK_DEPTH(4), .LC_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .PC     (pc),
    .instr  (instr),
    .cond   (cond),
    .start  (start),
    .BADR   (badr),
    .hlt    (hlt),
    .bra    (bra),
    .halted (halted),
    .err    (err),
    .sp     (sp)
  );

  // Clock and initial reset level
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: apply one cycle of inputs just after the edge and queue the response
  task automatic step(input logic r, input logic [9:0] p, input logic [15:0] ins,
                      input logic c, input logic s,
                      input logic eb, input logic eh, input logic [9:0] ea,
                      input logic ehl, input logic eer, input logic [2:0] esp);
    @(posedge clk);
    #1;
    rst   = r;
    pc    = p;
    instr = ins;
    cond  = c;
    start = s;
    exp_q.push_back({eb, eh, ea, ehl, eer, esp});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    int            id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        a  = {bra, hlt, badr, halted, err, sp};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL vec%0d: got bra=%b hlt=%b badr=%h halted=%b err=%b sp=%0d, expected bra=%b hlt=%b badr=%h halted=%b err=%b sp=%0d",
                   id, a[16], a[15], a[14:5], a[4], a[3], a[2:0],
                   e[16], e[15], e[14:5], e[4], e[3], e[2:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    rst = 1'b1; pc = '0; instr = '0; cond = 1'b0; start = 1'b0;
    n_checks = 0; n_errors = 0; vec_id = 0;

    // reset: increment encoding regardless of instr
    step(1, 10'h000, 16'h1120, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    // NOP then JMP
    step(0, 10'h000, 16'h0000, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    step(0, 10'h001, 16'h1120, 0, 0,  1, 0, 10'h120, 0, 0, 3'd0);
    // HALT (start on execute cycle ignored), five waits, then start
    step(0, 10'h010, 16'h2000, 0, 1,  1, 1, 10'h000, 0, 0, 3'd0);
    for (int i = 0; i < 5; i++)
      step(0, 10'h010, 16'h2000, 0, 0,  1, 1, 10'h000, 1, 0, 3'd0);
    step(0, 10'h010, 16'h2000, 0, 1,  0, 0, 10'h000, 1, 0, 3'd0);
    step(0, 10'h011, 16'h0000, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    // LDC 3, DJNZ three branches then fall-through, then LC stays 0
    step(0, 10'h020, 16'h3003, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    for (int i = 0; i < 3; i++)
      step(0, 10'h021, 16'h4020, 0, 0,  1, 0, 10'h020, 0, 0, 3'd0);
    step(0, 10'h021, 16'h4020, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    step(0, 10'h022, 16'h4020, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    // CALL at 0x3FF wraps the return address to 0x000
    step(0, 10'h3FF, 16'h5100, 0, 0,  1, 0, 10'h100, 0, 0, 3'd0);
    step(0, 10'h100, 16'h6000, 0, 0,  1, 0, 10'h000, 0, 0, 3'd1);
    step(0, 10'h000, 16'h0000, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    // Nested CALL/RET returns in LIFO order
    step(0, 10'h050, 16'h5060, 0, 0,  1, 0, 10'h060, 0, 0, 3'd0);
    step(0, 10'h060, 16'h5070, 0, 0,  1, 0, 10'h070, 0, 0, 3'd1);
    step(0, 10'h070, 16'h6000, 0, 0,  1, 0, 10'h061, 0, 0, 3'd2);
    step(0, 10'h061, 16'h6000, 0, 0,  1, 0, 10'h051, 0, 0, 3'd1);
    step(0, 10'h051, 16'h0000, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    // Overflow: fifth CALL holds and errors, start ignored, reset recovers
    step(0, 10'h200, 16'h5300, 0, 0,  1, 0, 10'h300, 0, 0, 3'd0);
    step(0, 10'h300, 16'h5310, 0, 0,  1, 0, 10'h310, 0, 0, 3'd1);
    step(0, 10'h310, 16'h5320, 0, 0,  1, 0, 10'h320, 0, 0, 3'd2);
    step(0, 10'h320, 16'h5330, 0, 0,  1, 0, 10'h330, 0, 0, 3'd3);
    step(0, 10'h330, 16'h5340, 0, 0,  1, 1, 10'h000, 0, 0, 3'd4);
    step(0, 10'h330, 16'h5340, 0, 1,  1, 1, 10'h000, 0, 1, 3'd4);
    step(0, 10'h330, 16'h0000, 0, 1,  1, 1, 10'h000, 0, 1, 3'd4);
    step(1, 10'h330, 16'h0000, 0, 0,  0, 0, 10'h000, 0, 1, 3'd4);
    step(0, 10'h000, 16'h0000, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    // RET on empty stack
    step(0, 10'h040, 16'h6000, 0, 0,  1, 1, 10'h000, 0, 0, 3'd0);
    step(0, 10'h040, 16'h6000, 0, 0,  1, 1, 10'h000, 0, 1, 3'd0);
    step(1, 10'h040, 16'h6000, 0, 0,  0, 0, 10'h000, 0, 1, 3'd0);
    // Illegal opcode 0xA
    step(0, 10'h000, 16'hA123, 0, 0,  1, 1, 10'h000, 0, 0, 3'd0);
    step(0, 10'h000, 16'hA123, 0, 0,  1, 1, 10'h000, 0, 1, 3'd0);
    step(1, 10'h000, 16'hA123, 0, 0,  0, 0, 10'h000, 0, 1, 3'd0);
    // JC with cond low / high
    step(0, 10'h080, 16'h7155, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);
    step(0, 10'h081, 16'h7155, 1, 0,  1, 0, 10'h155, 0, 0, 3'd0);
    step(0, 10'h155, 16'h0000, 0, 0,  0, 0, 10'h000, 0, 0, 3'd0);

    // Drain the scoreboard within a bounded number of cycles
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d responses never compared, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Instruction-decode controller driving the program-counter sequencer's `BADR`, `hlt` and `bra` inputs. Each cycle it decodes the instruction addressed by the current `PC` and produces one of three next-PC requests: increment, branch to `BADR`, or hold. Internal state covers a run/halt/error FSM, a loop counter, and a return-address stack. One instruction retires per clock; the instruction memory is asynchronous-read and external.

## Interface
Parameters:
- `STACK_DEPTH`, 4: return-stack entries, ≥2, power of two.
- `LC_W`, 8: loop-counter width, ≤10.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `PC` in 10: current program counter from the sequencer.
- `instr` in 16: instruction word at `PC`, valid in the same cycle. Fields: `[15:12]` opcode, `[9:0]` addr/imm.
- `cond` in 1: external condition flag.
- `start` in 1: resume request, level-sampled.
- `BADR` out 10: branch target.
- `hlt` out 1: with `bra`=1, hold PC.
- `bra` out 1: 0 selects PC+1; 1 selects `BADR`, or hold if `hlt`=1.
- `halted` out 1: registered, 1 in state HALTED.
- `err` out 1: registered, 1 in state ERR.
- `sp` out log2(STACK_DEPTH)+1: registered stack occupancy.

## Operation
- Next-PC encoding:
  - increment: `bra`=0, `hlt`=0, `BADR`=0.
  - branch: `bra`=1, `hlt`=0.
  - hold: `bra`=1, `hlt`=1, `BADR`=0.
- FSM states: RUN, HALTED, ERR.
  - Reset: state RUN, LC=0, sp=0, all stack entries 0, `halted`=0, `err`=0.
  - While `rst`=1: outputs are increment encoding, with `BADR`=0.
- RUN decode:
  - 0x0 NOP: increment.
  - 0x1 JMP: branch, `BADR`=`instr[9:0]`.
  - 0x2 HALT: hold; next state HALTED.
  - 0x3 LDC: LC <= `instr[LC_W-1:0]`; increment.
  - 0x4 DJNZ: if LC≠0, LC <= LC−1 and branch to `instr[9:0]`. If LC=0, increment and LC stays 0.
  - 0x5 CALL: if sp<STACK_DEPTH, push (PC+1) mod 1024, sp+1, branch to `instr[9:0]`. If full, hold and go to ERR; stack is unchanged.
  - 0x6 RET: if sp>0, pop, sp−1, `BADR`=top entry, branch. If empty, hold and go to ERR.
  - 0x7 JC: if `cond`=1, branch to `instr[9:0]`; else increment.
  - 0x8–0xF: illegal; hold and go to ERR.
- HALTED: `instr` is ignored.
  - `start`=0: hold.
  - `start`=1: increment (leaves the HALT word); next state RUN.
- ERR: hold regardless of `instr`/`start`. Exit only via reset.
- Stack is LIFO, sp counts valid entries. LC and stack modify only on the cycle the instruction executes in RUN.

## Timing
- `BADR`/`hlt`/`bra` are combinational from `instr`, `cond`, `start`, state, LC, stack top and `PC`. The sequencer registers the decision at the next rising edge.
- State, LC, sp, `halted` and `err` update at that same edge. `halted`/`err` assert the cycle after HALT or the error-causing instruction.
- `start` asserted on the HALT-execution cycle itself (state still RUN) is ignored. The block still enters HALTED.
- Throughput: one instruction per cycle; no stalls except hold states.
- Reset mid-operation: all state cleared at the edge; a pending push/pop is discarded.

## Test plan
- Reset then NOP at 0x000, JMP 0x120 at 0x001 -> increment, then `bra`=1 `BADR`=0x120; PC sequence 0,1,0x120.
- HALT at 0x010, `start` low 5 cycles, then high 1 cycle -> `bra`=`hlt`=1 for 6 cycles (HALT-execution cycle plus 5 waits), `halted`=1 from cycle after HALT; `start` cycle gives `bra`=0; PC 0x010 held then 0x011, `halted`=0.
- LDC 3 at 0x020, DJNZ 0x020 at 0x021 -> DJNZ branches to 0x020 three times (LC 3→2→1→0), fourth DJNZ falls through to 0x022.
- CALL 0x100 at 0x3FF, RET at 0x100 -> push 0x000, sp=1, branch 0x100; RET branches to 0x000, sp=0.
- Five nested CALLs (STACK_DEPTH=4) -> fifth gives hold, `err`=1 next cycle, sp stays 4; `start`=1 has no effect; `rst` returns to RUN with sp=0.
- RET with sp=0, and opcode 0xA in separate runs -> each enters ERR with PC held. JC with `cond`=0/1 -> increment/branch.
